// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1/8N2 serialiser with a small byte FIFO in front.
// Line outputs are registered, so they trail the FSM state by one clock.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  output logic [1:0] o_Debug_State
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST  = TW'(CLKS_PER_BIT * STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Handshake: a byte is taken on any rising edge where i_Tx_DV and o_Tx_Ready
  // are both high; o_Tx_Ready depends only on the registered occupancy count.

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_empty;

  assign o_Tx_Ready = (count != FULL_COUNT);
  assign push       = i_Tx_DV && o_Tx_Ready;
  assign fifo_empty = (count == '0);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset && push) mem[wr_ptr] <= i_Tx_Byte;
  end

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          serial_n, active_n, done_n;

  assign o_Debug_State = state;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      o_Tx_Serial <= serial_n;
      o_Tx_Active <= active_n;
      o_Tx_Done   <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    serial_n  = 1'b1;
    active_n  = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          timer_n = '0;
          state_n = START;
        end
      end
      START: begin
        serial_n = 1'b0;
        active_n = 1'b1;
        if (timer == BIT_LAST) begin
          timer_n   = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DATA: begin
        serial_n = shift[0];
        active_n = 1'b1;
        if (timer == BIT_LAST) begin
          timer_n = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      STOP: begin
        active_n = 1'b1;
        if (timer == STOP_LAST) begin
          done_n  = 1'b1;
          timer_n = '0;
          // Chain straight into the next frame when more bytes are waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: two instances (1 and 2 stop bits) share stimulus and are
// checked every cycle against a waveform-queue model, plus a line decoder and literal checks.
module tb_uart_transmitter;

  localparam int C = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       ready [2];
  logic       serial [2];
  logic       active [2];
  logic       done [2];
  logic [1:0] dbg [2];

  uart_transmitter #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .STOP_BITS(1)) u_dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(ready[0]), .o_Tx_Serial(serial[0]), .o_Tx_Active(active[0]),
    .o_Tx_Done(done[0]), .o_Debug_State(dbg[0])
  );

  uart_transmitter #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .STOP_BITS(2)) u_dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(ready[1]), .o_Tx_Serial(serial[1]), .o_Tx_Active(active[1]),
    .o_Tx_Done(done[1]), .o_Debug_State(dbg[1])
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit live = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // behavioural model: per instance a byte FIFO and a queue of future {serial,active,done}
  logic [7:0] mq [2][$];
  logic [2:0] fq [2][$];
  logic [7:0] exp_q [2][$];
  logic [2:0] exp_out [2];
  logic       exp_rdy [2];

  // line decoder state
  bit         busy [2];
  int         dcnt [2];
  logic [7:0] dsh [2];
  logic       prev [2];
  logic [7:0] got_q [2][$];
  int         st_q [2][$];
  int         dn_q [2][$];

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        live = 1'b1;
        mq[k].delete();
        fq[k].delete();
        exp_q[k].delete();
        exp_out[k] = 3'b100;
        exp_rdy[k] = 1'b1;
        busy[k] = 1'b0;
        prev[k] = 1'b1;
      end else if (live) begin
        bit rdy;
        rdy = mq[k].size() < D;
        if (mq[k].size() > 0 && fq[k].size() <= 1) begin
          logic [7:0] b;
          int nstop;
          b = mq[k].pop_front();
          nstop = C * (k + 1);
          if (fq[k].size() == 0) fq[k].push_back(3'b100);
          for (int i = 0; i < C; i++) fq[k].push_back(3'b010);
          for (int j = 0; j < 8; j++)
            for (int i = 0; i < C; i++) fq[k].push_back({b[j], 2'b10});
          for (int i = 0; i < nstop; i++) fq[k].push_back((i == nstop - 1) ? 3'b111 : 3'b110);
          exp_q[k].push_back(b);
        end
        if (dv && rdy) mq[k].push_back(tx_byte);
        exp_out[k] = (fq[k].size() > 0) ? fq[k].pop_front() : 3'b100;
        exp_rdy[k] = mq[k].size() < D;
      end
    end
  end

  // compare process + decoder, away from the active edge
  always @(negedge clk) begin
    if (live) begin
      for (int k = 0; k < 2; k++) begin
        check(k ? "s2_line_active_done" : "s1_line_active_done",
              int'({serial[k], active[k], done[k]}), int'(exp_out[k]));
        check(k ? "s2_ready" : "s1_ready", int'(ready[k]), int'(exp_rdy[k]));
        if (done[k]) dn_q[k].push_back(cyc);
        if (!busy[k]) begin
          if (prev[k] && !serial[k]) begin
            busy[k] = 1'b1;
            dcnt[k] = 0;
            st_q[k].push_back(cyc);
          end
        end else begin
          dcnt[k]++;
          if (dcnt[k] >= C + C / 2 && dcnt[k] < 9 * C && (dcnt[k] - C / 2) % C == 0)
            dsh[k][(dcnt[k] - C - C / 2) / C] = serial[k];
          if (dcnt[k] == 9 * C + C / 2) begin
            check(k ? "s2_stop_bit" : "s1_stop_bit", int'(serial[k]), 1);
            got_q[k].push_back(dsh[k]);
            if (exp_q[k].size() > 0) check(k ? "s2_decoded" : "s1_decoded", int'(dsh[k]), int'(exp_q[k].pop_front()));
            else check(k ? "s2_unexpected_frame" : "s1_unexpected_frame", 1, 0);
            busy[k] = 1'b0;
          end
        end
        prev[k] = serial[k];
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      got_q[k].delete();
      st_q[k].delete();
      dn_q[k].delete();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output int wc);
    @(negedge clk);
    dv = 1'b1;
    tx_byte = b;
    @(negedge clk);
    wc = cyc;
    dv = 1'b0;
    tx_byte = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_got(input int k, input int n, input int budget);
    int t;
    t = 0;
    while (got_q[k].size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (got_q[k].size() < n) check("wait_got_timeout", got_q[k].size(), n);
  endtask

  initial begin
    int wc, acc, t;
    logic [7:0] seq [4];
    seq = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

    // 1: idle after reset
    do_reset();
    repeat (100) @(negedge clk);
    check("idle_serial", int'(serial[0]), 1);
    check("idle_ready", int'(ready[0]), 1);
    check("idle_active", int'(active[0]), 0);
    check("idle_done_count", dn_q[0].size(), 0);

    // 2: single 0x55
    write_byte(8'h55, wc);
    wait_got(0, 1, 200);
    if (got_q[0].size() >= 1) check("b55_value", int'(got_q[0][0]), 8'h55);
    if (st_q[0].size() >= 1) check("b55_start_latency", st_q[0][0] - wc, 2);
    repeat (C) @(negedge clk);
    if (dn_q[0].size() >= 1 && st_q[0].size() >= 1) check("b55_done_at_80", dn_q[0][0] - st_q[0][0] + 1, 80);
    else check("b55_done_seen", dn_q[0].size(), 1);

    // 3: back-to-back burst
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dv = 1'b1;
      tx_byte = seq[i];
    end
    @(negedge clk);
    dv = 1'b0;
    wait_got(0, 4, 600);
    for (int i = 0; i < 4; i++)
      if (got_q[0].size() > i) check("burst_byte", int'(got_q[0][i]), int'(seq[i]));
    for (int i = 1; i < 4; i++)
      if (st_q[0].size() > i) check("burst_spacing", st_q[0][i] - st_q[0][i-1], 80);
    wait_got(1, 4, 600);
    repeat (3 * C) @(negedge clk);

    // 4: hold write strobe until the first completed frame
    do_reset();
    @(negedge clk);
    dv = 1'b1;
    tx_byte = 8'h00;
    acc = 0;
    t = 0;
    while (!done[0] && t < 200) begin
      if (ready[0]) acc++;
      @(negedge clk);
      if (!done[0]) tx_byte = tx_byte + 8'd1;
      t++;
    end
    check("accepted_before_done", acc, D + 1);
    dv = 1'b0;
    wait_got(0, 5, 600);
    for (int i = 0; i < 5; i++)
      if (got_q[0].size() > i) check("hold_byte_order", int'(got_q[0][i]), i);
    wait_got(1, 5, 800);

    // 5: reset during data bit 3 of 0xC3
    do_reset();
    write_byte(8'hC3, wc);
    t = 0;
    while (!(busy[0] && dcnt[0] >= 4 * C + 3) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("abort_reached_bit3", int'(busy[0] && dcnt[0] >= 4 * C + 3), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_serial_high", int'(serial[0]), 1);
    check("abort_ready", int'(ready[0]), 1);
    check("abort_active", int'(active[0]), 0);
    repeat (100) @(negedge clk);
    check("abort_no_done", dn_q[0].size(), 0);
    write_byte(8'h81, wc);
    wait_got(0, 1, 200);
    if (got_q[0].size() >= 1) check("after_abort_byte", int'(got_q[0][0]), 8'h81);

    // 6: two stop bits, 0x0F twice
    do_reset();
    write_byte(8'h0F, wc);
    write_byte(8'h0F, wc);
    wait_got(1, 2, 400);
    for (int i = 0; i < 2; i++)
      if (got_q[1].size() > i) check("s2_byte", int'(got_q[1][i]), 8'h0F);
    if (st_q[1].size() >= 2) check("s2_spacing", st_q[1][1] - st_q[1][0], 88);
    repeat (2 * C) @(negedge clk);
    if (dn_q[1].size() >= 1 && st_q[1].size() >= 1) check("s2_frame_len", dn_q[1][0] - st_q[1][0] + 1, 88);

    // random traffic on both instances
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      dv = ($urandom_range(0, 9) < 2);
      tx_byte = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1999) == 0) rst = 1'b1;
      else rst = 1'b0;
    end
    @(negedge clk);
    dv = 1'b0;
    rst = 1'b0;
    repeat (D * 110 * 2) @(negedge clk);
    check("drained_s1", exp_q[0].size(), 0);
    check("drained_s2", exp_q[1].size(), 0);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
